// File: rtl/key_conditioner.sv
// Push-button front end: two-flop synchroniser, per-key debounce FSM and
// registered press / step / release pulses with optional auto-repeat on step.
module key_conditioner #(
    parameter int NUM_KEYS         = 3,
    parameter int DEBOUNCE_CYC     = 1048576,
    parameter int REPEAT_DELAY_CYC = 25000000,
    parameter int REPEAT_RATE_CYC  = 5000000,
    parameter int CNT_W            = 26
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_KEYS-1:0] key_n_in,
    input  logic [NUM_KEYS-1:0] repeat_en,
    output logic [NUM_KEYS-1:0] key_level,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_step,
    output logic [NUM_KEYS-1:0] key_release
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_PRESS_DB = 3'd1;
    localparam logic [2:0] ST_HELD     = 3'd2;
    localparam logic [2:0] ST_REPEAT   = 3'd3;
    localparam logic [2:0] ST_REL_DB   = 3'd4;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(REPEAT_DELAY_CYC - 1);
    localparam logic [CNT_W-1:0] RR_LAST  = CNT_W'(REPEAT_RATE_CYC - 1);

    logic [NUM_KEYS-1:0] sync1_q, sync2_q;
    logic [NUM_KEYS-1:0] pressed_s;
    logic [2:0]          state_q [NUM_KEYS];
    logic [2:0]          state_d [NUM_KEYS];
    logic [CNT_W-1:0]    cnt_q   [NUM_KEYS];
    logic [CNT_W-1:0]    cnt_d   [NUM_KEYS];
    logic [NUM_KEYS-1:0] level_q, level_d;
    logic [NUM_KEYS-1:0] press_q, press_d;
    logic [NUM_KEYS-1:0] step_q, step_d;
    logic [NUM_KEYS-1:0] release_q, release_d;

    assign pressed_s = ~sync2_q;

    // Synchronisers reset to the released (high) level so reset exit is quiet.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= {NUM_KEYS{1'b1}};
            sync2_q <= {NUM_KEYS{1'b1}};
        end else begin
            sync1_q <= key_n_in;
            sync2_q <= sync1_q;
        end
    end

    // Per-key debounce / repeat FSM; every counter restarts from zero on each state change.
    always_comb begin
        level_d   = level_q;
        press_d   = {NUM_KEYS{1'b0}};
        step_d    = {NUM_KEYS{1'b0}};
        release_d = {NUM_KEYS{1'b0}};
        for (int k = 0; k < NUM_KEYS; k++) begin
            state_d[k] = state_q[k];
            cnt_d[k]   = cnt_q[k];
            case (state_q[k])
                ST_IDLE: begin
                    cnt_d[k] = CNT_ZERO;
                    if (pressed_s[k]) begin
                        state_d[k] = ST_PRESS_DB;
                    end else begin
                        state_d[k] = ST_IDLE;
                    end
                end
                ST_PRESS_DB: begin
                    if (!pressed_s[k]) begin
                        state_d[k] = ST_IDLE;
                        cnt_d[k]   = CNT_ZERO;
                    end else if (cnt_q[k] == DB_LAST) begin
                        state_d[k] = ST_HELD;
                        cnt_d[k]   = CNT_ZERO;
                        level_d[k] = 1'b1;
                        press_d[k] = 1'b1;
                        step_d[k]  = 1'b1;
                    end else begin
                        cnt_d[k] = cnt_q[k] + CNT_ONE;
                    end
                end
                ST_HELD: begin
                    if (!pressed_s[k]) begin
                        state_d[k] = ST_REL_DB;
                        cnt_d[k]   = CNT_ZERO;
                    end else if (!repeat_en[k]) begin
                        cnt_d[k] = CNT_ZERO;
                    end else if (cnt_q[k] == RD_LAST) begin
                        state_d[k] = ST_REPEAT;
                        cnt_d[k]   = CNT_ZERO;
                        step_d[k]  = 1'b1;
                    end else begin
                        cnt_d[k] = cnt_q[k] + CNT_ONE;
                    end
                end
                ST_REPEAT: begin
                    if (!pressed_s[k]) begin
                        state_d[k] = ST_REL_DB;
                        cnt_d[k]   = CNT_ZERO;
                    end else if (!repeat_en[k]) begin
                        state_d[k] = ST_HELD;
                        cnt_d[k]   = CNT_ZERO;
                    end else if (cnt_q[k] == RR_LAST) begin
                        cnt_d[k]  = CNT_ZERO;
                        step_d[k] = 1'b1;
                    end else begin
                        cnt_d[k] = cnt_q[k] + CNT_ONE;
                    end
                end
                ST_REL_DB: begin
                    // A bounce back to pressed returns to HELD, restarting the repeat delay.
                    if (pressed_s[k]) begin
                        state_d[k] = ST_HELD;
                        cnt_d[k]   = CNT_ZERO;
                    end else if (cnt_q[k] == DB_LAST) begin
                        state_d[k]   = ST_IDLE;
                        cnt_d[k]     = CNT_ZERO;
                        level_d[k]   = 1'b0;
                        release_d[k] = 1'b1;
                    end else begin
                        cnt_d[k] = cnt_q[k] + CNT_ONE;
                    end
                end
                default: begin
                    state_d[k] = ST_IDLE;
                    cnt_d[k]   = CNT_ZERO;
                    level_d[k] = 1'b0;
                end
            endcase
        end
    end

    // FSM state, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_KEYS; k++) begin
                state_q[k] <= ST_IDLE;
                cnt_q[k]   <= CNT_ZERO;
            end
            level_q   <= {NUM_KEYS{1'b0}};
            press_q   <= {NUM_KEYS{1'b0}};
            step_q    <= {NUM_KEYS{1'b0}};
            release_q <= {NUM_KEYS{1'b0}};
        end else begin
            for (int k = 0; k < NUM_KEYS; k++) begin
                state_q[k] <= state_d[k];
                cnt_q[k]   <= cnt_d[k];
            end
            level_q   <= level_d;
            press_q   <= press_d;
            step_q    <= step_d;
            release_q <= release_d;
        end
    end

    assign key_level   = level_q;
    assign key_press   = press_q;
    assign key_step    = step_q;
    assign key_release = release_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Scoreboard bench for key_conditioner: expected pulse events (cycle, kind, key)
// are queued when stimulus is driven and matched as the DUT emits pulses.
module tb_key_conditioner;

    localparam int NK  = 3;
    localparam int DB  = 8;
    localparam int RD  = 40;
    localparam int RR  = 10;
    localparam int LAT = DB + 3;

    localparam logic [3:0] K_PRESS = 4'd0;
    localparam logic [3:0] K_STEP  = 4'd1;
    localparam logic [3:0] K_REL   = 4'd2;

    logic          clk = 1'b0;
    logic          rst;
    logic [NK-1:0] key_n_in;
    logic [NK-1:0] repeat_en;
    logic [NK-1:0] key_level;
    logic [NK-1:0] key_press;
    logic [NK-1:0] key_step;
    logic [NK-1:0] key_release;

    int          cyc       = 0;
    int          n_checks  = 0;
    int          n_pass    = 0;
    int          step1_cnt = 0;
    int          press1_cnt = 0;
    logic [31:0] exp_q[$];

    key_conditioner #(
        .NUM_KEYS        (NK),
        .DEBOUNCE_CYC    (DB),
        .REPEAT_DELAY_CYC(RD),
        .REPEAT_RATE_CYC (RR),
        .CNT_W           (26)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .key_n_in   (key_n_in),
        .repeat_en  (repeat_en),
        .key_level  (key_level),
        .key_press  (key_press),
        .key_step   (key_step),
        .key_release(key_release)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ev(input int c, input logic [3:0] kind, input int k);
        return {c[23:0], kind, k[3:0]};
    endfunction

    task automatic expect_ev(input int c, input logic [3:0] kind, input int k);
        exp_q.push_back(ev(c, kind, k));
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Monitor: sample just after each rising edge, match pulses against the queue head.
    initial begin
        logic [NK-1:0] vec;
        logic [31:0]   obs;
        logic [31:0]   head;
        forever begin
            @(posedge clk);
            #1;
            while (exp_q.size() > 0 && int'(exp_q[0][31:8]) < cyc) begin
                check_eq("missed_event", 32'hFFFF_FFFF, exp_q[0]);
                void'(exp_q.pop_front());
            end
            if (key_step[1] === 1'b1) step1_cnt++;
            if (key_press[1] === 1'b1) press1_cnt++;
            for (int kind = 0; kind < 3; kind++) begin
                for (int k = 0; k < NK; k++) begin
                    vec = (kind == 0) ? key_press : (kind == 1) ? key_step : key_release;
                    if (vec[k] !== 1'b0) begin
                        obs  = ev(cyc, 4'(kind), k);
                        head = (exp_q.size() > 0) ? exp_q[0] : 32'h0;
                        check_eq("pulse_event", obs, head);
                        if (exp_q.size() > 0 && obs == head) void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish in time, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1);
    end

    initial begin
        int c, d, d2, g, p, r, n_exp;
        rst       = 1'b1;
        key_n_in  = 3'b111;
        repeat_en = 3'b000;

        // Reset and idle
        repeat (3) begin
            @(negedge clk);
            check_eq("reset_outputs", {20'h0, key_level, key_press, key_step, key_release}, 32'h0);
        end
        rst = 1'b0;
        repeat (100) begin
            @(negedge clk);
            check_eq("idle_outputs", {20'h0, key_level, key_press, key_step, key_release}, 32'h0);
        end

        // Reset pulse in the middle of PRESS_DB on key 0; key stays down
        c = cyc;
        key_n_in[0] = 1'b0;
        wait_until(c + 6);
        rst = 1'b1;
        @(negedge clk);
        check_eq("rst_mid_db_outputs", {20'h0, key_level, key_press, key_step, key_release}, 32'h0);
        rst = 1'b0;
        d = cyc;
        expect_ev(d + LAT, K_PRESS, 0);
        expect_ev(d + LAT, K_STEP, 0);
        expect_ev(d + 20 + LAT, K_REL, 0);
        wait_until(d + LAT);
        check_eq("rst_mid_db_level", 32'(key_level), 32'h1);
        wait_until(d + 20);
        key_n_in[0] = 1'b1;
        wait_until(d + 20 + LAT + 5);
        check_eq("rst_mid_db_level_off", 32'(key_level), 32'h0);

        // Clean press and release on key 1
        c = cyc;
        expect_ev(c + LAT, K_PRESS, 1);
        expect_ev(c + LAT, K_STEP, 1);
        expect_ev(c + 30 + LAT, K_REL, 1);
        key_n_in[1] = 1'b0;
        wait_until(c + LAT - 1);
        check_eq("clean_level_before", 32'(key_level), 32'h0);
        wait_until(c + LAT);
        check_eq("clean_level_rise", 32'(key_level), 32'h2);
        check_eq("clean_press_vec", {16'h0, 5'h0, key_press, 5'h0, key_step}, {16'h0, 8'h02, 8'h02});
        wait_until(c + 30);
        key_n_in[1] = 1'b1;
        wait_until(c + 30 + LAT - 1);
        check_eq("clean_level_held", 32'(key_level), 32'h2);
        wait_until(c + 30 + LAT);
        check_eq("clean_level_fall", 32'(key_level), 32'h0);
        check_eq("clean_release_vec", 32'(key_release), 32'h2);
        wait_until(c + 30 + LAT + 5);

        // Bounce on key 2: 5 low, 2 high, 6 low, then an 8-cycle low (one short of acceptance)
        c = cyc;
        key_n_in[2] = 1'b0; wait_until(c + 5);
        key_n_in[2] = 1'b1; wait_until(c + 7);
        key_n_in[2] = 1'b0; wait_until(c + 13);
        key_n_in[2] = 1'b1; wait_until(c + 30);
        key_n_in[2] = 1'b0; wait_until(c + 38);
        key_n_in[2] = 1'b1; wait_until(c + 55);
        check_eq("bounce_level", 32'(key_level), 32'h0);
        // 9-cycle low is just long enough
        c = cyc;
        expect_ev(c + LAT, K_PRESS, 2);
        expect_ev(c + LAT, K_STEP, 2);
        expect_ev(c + 9 + LAT, K_REL, 2);
        key_n_in[2] = 1'b0; wait_until(c + 9);
        key_n_in[2] = 1'b1; wait_until(c + 9 + LAT + 5);
        check_eq("bounce9_level_off", 32'(key_level), 32'h0);

        // Auto-repeat: hold key 1 for 200 cycles; steps at press, +RD, then every RR
        repeat_en  = 3'b111;
        step1_cnt  = 0;
        press1_cnt = 0;
        c = cyc;
        p = c + LAT;
        r = c + 200;
        expect_ev(p, K_PRESS, 1);
        expect_ev(p, K_STEP, 1);
        n_exp = 1;
        for (int t = p + RD; t <= r + 2; t += RR) begin
            expect_ev(t, K_STEP, 1);
            n_exp++;
        end
        expect_ev(r + LAT, K_REL, 1);
        key_n_in[1] = 1'b0;
        wait_until(r);
        key_n_in[1] = 1'b1;
        wait_until(r + LAT + 5);
        check_eq("repeat_step_count", step1_cnt, n_exp);
        check_eq("repeat_press_count", press1_cnt, 1);

        // Repeat gating and release glitch in HELD
        c = cyc;
        p = c + LAT;
        d = p + 65;
        d2 = p + 96;
        g = d2 + 23;
        r = d2 + 80;
        expect_ev(p, K_PRESS, 1);
        expect_ev(p, K_STEP, 1);
        expect_ev(p + RD, K_STEP, 1);
        expect_ev(p + RD + RR, K_STEP, 1);
        expect_ev(p + RD + 2 * RR, K_STEP, 1);
        for (int t = g + 3 + RD; t <= r + 2; t += RR) expect_ev(t, K_STEP, 1);
        expect_ev(r + LAT, K_REL, 1);
        key_n_in[1] = 1'b0;
        wait_until(d);
        repeat_en[1] = 1'b0;
        wait_until(d2 - 1);
        check_eq("gated_level", 32'(key_level), 32'h2);
        wait_until(d2);
        repeat_en[1] = 1'b1;
        wait_until(d2 + 20);
        key_n_in[1] = 1'b1;
        wait_until(g);
        key_n_in[1] = 1'b0;
        wait_until(g + 1);
        check_eq("glitch_level", 32'(key_level), 32'h2);
        wait_until(r);
        key_n_in[1] = 1'b1;
        wait_until(r + LAT + 5);
        check_eq("gated_level_off", 32'(key_level), 32'h0);
        repeat_en = 3'b000;

        // Simultaneous keys 0 and 2
        c = cyc;
        expect_ev(c + LAT, K_PRESS, 0);
        expect_ev(c + LAT, K_PRESS, 2);
        expect_ev(c + LAT, K_STEP, 0);
        expect_ev(c + LAT, K_STEP, 2);
        expect_ev(c + 25 + LAT, K_REL, 0);
        expect_ev(c + 25 + LAT, K_REL, 2);
        key_n_in = 3'b010;
        wait_until(c + LAT);
        check_eq("simul_press", 32'(key_press), 32'h5);
        check_eq("simul_step", 32'(key_step), 32'h5);
        check_eq("simul_level", 32'(key_level), 32'h5);
        wait_until(c + 25);
        key_n_in = 3'b111;
        wait_until(c + 25 + LAT);
        check_eq("simul_release", 32'(key_release), 32'h5);
        check_eq("simul_level_off", 32'(key_level), 32'h0);

        wait_until(cyc + 20);
        check_eq("queue_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
